// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline types: memory access widths, data-memory request/response
// records and the data-memory responder state encoding.
package rv32_pipeline_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_width_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

    // Only the five RV32I load encodings name a real access width.
    function automatic logic funct3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load alignment: picks the addressed byte/half out of a raw 32-bit word
// and sign- or zero-extends it according to funct3.
module rv32_load_align
    import rv32_pipeline_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = raw_word[8*gi +: 8];
    end

    always_comb begin
        byte_sel = lanes[byte_off];
        half_sel = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
        rdata    = '0;
        case (funct3)
            MEM_B:   rdata = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  rdata = {24'h0, byte_sel};
            MEM_H:   rdata = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  rdata = {16'h0, half_sel};
            MEM_W:   rdata = raw_word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, fixed
// access latency, byte-lane stores, aligned/extended loads and error flagging.
module rv32_dmem_responder
    import rv32_pipeline_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    dmem_req_t   req_reg, req_next;
    dmem_req_t   in_req, acc_req;
    logic        err_reg;
    logic [31:0] rd_word_reg;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          acc_err;
    logic [3:0]    lane_en;
    logic [31:0]   wdata_rep;
    logic          accept;
    logic          enter_resp;
    logic [31:0]   aligned;
    dmem_resp_t    resp;

    assign req_ready = rst_n && (state_reg == DM_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_req    = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
    // With zero latency the RAM access happens on the accept edge itself.
    assign acc_req   = (state_reg == DM_IDLE) ? in_req : req_reg;

    always_comb begin
        offset    = acc_req.addr - BASE_ADDR;
        word_idx  = offset[2 +: AW];
        acc_err   = (offset >= SPAN) || !funct3_legal(acc_req.funct3)
                    || (acc_req.we && acc_req.funct3[2]);
        lane_en   = 4'hF;
        wdata_rep = acc_req.wdata;
        case (acc_req.funct3[1:0])
            2'b00: begin
                lane_en   = 4'b0001 << acc_req.addr[1:0];
                wdata_rep = {4{acc_req.wdata[7:0]}};
            end
            2'b01: begin
                if (acc_req.addr[0]) acc_err = 1'b1;
                lane_en   = 4'b0011 << acc_req.addr[1:0];
                wdata_rep = {2{acc_req.wdata[15:0]}};
            end
            default: begin
                if (acc_req.addr[1:0] != 2'b00) acc_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        enter_resp = 1'b0;
        case (state_reg)
            DM_IDLE: begin
                if (accept) begin
                    req_next = in_req;
                    cnt_next = '0;
                    if (LATENCY == 0) begin
                        state_next = DM_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DM_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DM_RESP: state_next = DM_IDLE;
            default: state_next = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= DM_IDLE;
            cnt_reg   <= '0;
            req_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            if (enter_resp) err_reg <= acc_err;
        end
    end

    // RAM is never reset; gating on rst_n makes a reset mid-access abort the write.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp) begin
            if (acc_req.we && !acc_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
            rd_word_reg <= mem[word_idx];
        end
    end

    rv32_load_align u_align (
        .raw_word (rd_word_reg),
        .byte_off (req_reg.addr[1:0]),
        .funct3   (req_reg.funct3),
        .rdata    (aligned)
    );

    assign resp.rdata = (state_reg == DM_RESP && !err_reg && !req_reg.we) ? aligned : '0;
    assign resp.err   = (state_reg == DM_RESP) && err_reg;

    assign resp_valid = (state_reg == DM_RESP);
    assign resp_rdata = resp.rdata;
    assign resp_err   = resp.err;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Bench for rv32_dmem_responder: three instances (latency 1, 3, 0) checked every
// cycle against a byte-addressed memory model, plus literal expected values.
module tb_rv32_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [2:0]  req_funct3 [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        rv32_dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((gi == 0) ? 1 : (gi == 1) ? 3 : 0),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[gi]),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_we     (req_we[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .req_funct3 (req_funct3[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int negcnt = 0;
    bit chk_on = 1'b0;

    bit          pend  [3];
    int          due   [3];
    logic        p_we  [3];
    logic [31:0] p_addr[3];
    logic [31:0] p_wd  [3];
    logic [2:0]  p_f3  [3];
    logic [31:0] l_rd  [3];
    logic        l_er  [3];

    logic [7:0] mem_b [int];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    // Byte-addressed view of memory; applies stores and returns load results.
    function automatic void model_access(input int k, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [2:0] f3,
                                         output logic [31:0] rd, output logic er);
        int size;
        longint off;
        int key;
        logic [31:0] v;
        rd  = '0;
        er  = 1'b0;
        off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || off < 0 || off >= 4 * DEPTH || (int'(addr[1:0]) % size) != 0
            || (we && f3[2])) begin
            er = 1'b1;
            return;
        end
        key = k * (1 << 20) + int'(off);
        if (we) begin
            for (int i = 0; i < size; i++) mem_b[key + i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[key + i];
            case (f3)
                3'd0:    rd = 32'($signed(v[7:0]));
                3'd1:    rd = 32'($signed(v[15:0]));
                default: rd = v;
            endcase
        end
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic        ev;
        logic [31:0] m_rd;
        logic        m_er;
        negcnt++;
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                ev = pend[k] && (due[k] == negcnt);
                chk("req_ready", k, 32'(req_ready[k]), 32'(rst_n[k] && !pend[k]));
                chk("resp_valid", k, 32'(resp_valid[k]), 32'(ev));
                if (!rst_n[k]) begin
                    chk("reset_rdata", k, resp_rdata[k], 32'h0);
                    chk("reset_err", k, 32'(resp_err[k]), 32'h0);
                end
                if (ev) begin
                    model_access(k, p_we[k], p_addr[k], p_wd[k], p_f3[k], m_rd, m_er);
                    chk("model_rdata", k, resp_rdata[k], m_rd);
                    chk("model_err", k, 32'(resp_err[k]), 32'(m_er));
                    chk("literal_rdata", k, resp_rdata[k], l_rd[k]);
                    chk("literal_err", k, 32'(resp_err[k]), 32'(l_er[k]));
                    $display("dut%0d %s addr=%h wdata=%h f3=%b -> rdata=%h err=%b",
                             k, p_we[k] ? "ST" : "LD", p_addr[k], p_wd[k], p_f3[k],
                             resp_rdata[k], resp_err[k]);
                    pend[k] = 1'b0;
                end
            end
        end
    end

    task automatic launch(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] lrd, input logic ler);
        @(negedge clk);
        #1;
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_funct3[k] = f3;
        p_we[k] = we; p_addr[k] = addr; p_wd[k] = wdata; p_f3[k] = f3;
        l_rd[k] = lrd; l_er[k] = ler;
        due[k]  = negcnt + lat_of(k) + 1;
        pend[k] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] lrd, input logic ler);
        int n;
        launch(k, we, addr, wdata, f3, lrd, ler);
        n = 0;
        while (pend[k] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pend[k]) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d addr=%h actual=no_response required=response", k, addr);
            pend[k] = 1'b0;
        end
    endtask

    // Reset lands while the access sits in WAIT; nothing may come back or be written.
    task automatic abort_xact(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        launch(k, 1'b1, addr, wdata, 3'b010, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        rst_n[k] = 1'b0;
        pend[k]  = 1'b0;
        @(negedge clk);
        #1;
        rst_n[k] = 1'b1;
        $display("dut%0d ST addr=%h wdata=%h aborted by reset", k, addr, wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_funct3[k] = '0; pend[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // Latency 1
        xact(0, 1'b1, 32'h2004, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
        xact(0, 1'b0, 32'h2007, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
        xact(0, 1'b0, 32'h2007, 32'h0,        3'b100, 32'h000000DE, 1'b0);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0);
        xact(0, 1'b0, 32'h2006, 32'h0,        3'b101, 32'h0000DEAD, 1'b0);
        xact(0, 1'b1, 32'h2005, 32'h00000012, 3'b000, 32'h0,        1'b0);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b010, 32'hDEAD12EF, 1'b0);
        xact(0, 1'b0, 32'h2002, 32'h0,        3'b010, 32'h0,        1'b1);
        xact(0, 1'b1, 32'h2000, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0);
        xact(0, 1'b1, 32'h2003, 32'h00007777, 3'b001, 32'h0,        1'b1);
        xact(0, 1'b0, 32'h2000, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0);
        xact(0, 1'b0, 32'h1FFC, 32'h0,        3'b010, 32'h0,        1'b1);
        xact(0, 1'b0, 32'h3000, 32'h0,        3'b010, 32'h0,        1'b1);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b011, 32'h0,        1'b1);
        xact(0, 1'b1, 32'h2006, 32'h00001234, 3'b001, 32'h0,        1'b0);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b010, 32'h123412EF, 1'b0);
        xact(0, 1'b1, 32'h2004, 32'h000000FF, 3'b100, 32'h0,        1'b1);
        xact(0, 1'b0, 32'h2004, 32'h0,        3'b010, 32'h123412EF, 1'b0);

        // Latency 3 with reset in the middle of WAIT
        xact(1, 1'b1, 32'h2008, 32'h11223344, 3'b010, 32'h0,        1'b0);
        abort_xact(1, 32'h2008, 32'h00000055);
        xact(1, 1'b0, 32'h2008, 32'h0,        3'b010, 32'h11223344, 1'b0);

        // Latency 0
        xact(2, 1'b1, 32'h2010, 32'hA5A5A5A5, 3'b010, 32'h0,        1'b0);
        xact(2, 1'b0, 32'h2010, 32'h0,        3'b000, 32'hFFFFFFA5, 1'b0);
        xact(2, 1'b0, 32'h2012, 32'h0,        3'b101, 32'h0000A5A5, 1'b0);
        xact(2, 1'b0, 32'h2010, 32'h0,        3'b010, 32'hA5A5A5A5, 1'b0);

        repeat (4) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
